// File: rtl/csa_sub_pipe.sv
// Two-stage pipelined carry-select subtractor, o_diff = i_sub_min - i_sub_sub, with valid/ready on both sides.
// Define CSA_SUB_OVF_EN to build signed-overflow detection; otherwise o_ovf is tied to 0.
module csa_sub_pipe #(
  parameter int WIDTH = 9,
  parameter int LOW_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_sub_min,
  input  logic [WIDTH-1:0] i_sub_sub,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int HIGH_W = WIDTH - LOW_W;
  localparam logic [HIGH_W:0] HI_ONE = {{HIGH_W{1'b0}}, 1'b1};

  logic             accept;
  logic             s2_adv;

  logic [LOW_W:0]   low_c;
  logic [LOW_W-1:0] low_diff;
  logic [HIGH_W:0]  hi_sum_b0;
  logic [HIGH_W:0]  hi_sum_b1;

  logic              s1_valid_reg;
  logic [LOW_W-1:0]  s1_low_diff_reg;
  logic              s1_low_borrow_reg;
  logic [HIGH_W-1:0] s1_hi0_diff_reg;
  logic              s1_hi0_borrow_reg;
  logic [HIGH_W-1:0] s1_hi1_diff_reg;
  logic              s1_hi1_borrow_reg;

  logic [HIGH_W-1:0] sel_hi_diff;
  logic              sel_borrow;
  logic [WIDTH-1:0]  diff_next;

  // Low ripple segment: a + ~b with carry-in 1, carry-out inverted is the low borrow.
  assign low_c[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 0; gi < LOW_W; gi++) begin : g_low
      logic p;
      assign p              = i_sub_min[gi] ^ ~i_sub_sub[gi];
      assign low_diff[gi]   = p ^ low_c[gi];
      assign low_c[gi+1]    = (i_sub_min[gi] & ~i_sub_sub[gi]) | (low_c[gi] & p);
    end
  endgenerate

  // Speculative upper halves: borrow-in 0 means carry-in 1, borrow-in 1 means carry-in 0.
  assign hi_sum_b0 = {1'b0, i_sub_min[WIDTH-1:LOW_W]} + {1'b0, ~i_sub_sub[WIDTH-1:LOW_W]} + HI_ONE;
  assign hi_sum_b1 = {1'b0, i_sub_min[WIDTH-1:LOW_W]} + {1'b0, ~i_sub_sub[WIDTH-1:LOW_W]};

  assign s2_adv  = s1_valid_reg & (~o_valid | i_ready);
  assign o_ready = ~s1_valid_reg | s2_adv;
  assign accept  = i_valid & o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg      <= 1'b0;
      s1_low_diff_reg   <= '0;
      s1_low_borrow_reg <= 1'b0;
      s1_hi0_diff_reg   <= '0;
      s1_hi0_borrow_reg <= 1'b0;
      s1_hi1_diff_reg   <= '0;
      s1_hi1_borrow_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg      <= 1'b1;
      s1_low_diff_reg   <= low_diff;
      s1_low_borrow_reg <= ~low_c[LOW_W];
      s1_hi0_diff_reg   <= hi_sum_b0[HIGH_W-1:0];
      s1_hi0_borrow_reg <= ~hi_sum_b0[HIGH_W];
      s1_hi1_diff_reg   <= hi_sum_b1[HIGH_W-1:0];
      s1_hi1_borrow_reg <= ~hi_sum_b1[HIGH_W];
    end else if (s2_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_comb begin
    sel_hi_diff = s1_hi0_diff_reg;
    sel_borrow  = s1_hi0_borrow_reg;
    if (s1_low_borrow_reg) begin
      sel_hi_diff = s1_hi1_diff_reg;
      sel_borrow  = s1_hi1_borrow_reg;
    end
  end

  assign diff_next = {sel_hi_diff, s1_low_diff_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
    end else if (s2_adv) begin
      o_valid  <= 1'b1;
      o_diff   <= diff_next;
      o_borrow <= sel_borrow;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef CSA_SUB_OVF_EN
  logic s1_a_msb_reg;
  logic s1_b_msb_reg;
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_msb_reg <= 1'b0;
      s1_b_msb_reg <= 1'b0;
    end else if (accept) begin
      s1_a_msb_reg <= i_sub_min[WIDTH-1];
      s1_b_msb_reg <= i_sub_sub[WIDTH-1];
    end
  end

  // Overflow when operand signs differ and the result sign differs from the minuend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (s2_adv) begin
      ovf_reg <= (s1_a_msb_reg ^ s1_b_msb_reg) & (s1_a_msb_reg ^ sel_hi_diff[HIGH_W-1]);
    end
  end

  assign o_ovf = ovf_reg;
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_sub_pipe.sv
// Directed self-checking bench for csa_sub_pipe at WIDTH=9, LOW_W=4.
module tb_csa_sub_pipe;

  logic       clk;
  logic       rst_n;
  logic [8:0] i_sub_min;
  logic [8:0] i_sub_sub;
  logic       i_valid;
  logic       o_ready;
  logic [8:0] o_diff;
  logic       o_borrow;
  logic       o_ovf;
  logic       o_valid;
  logic       i_ready;

  int checks = 0;
  int errors = 0;

  csa_sub_pipe #(.WIDTH(9), .LOW_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sub_min(i_sub_min), .i_sub_sub(i_sub_sub), .i_valid(i_valid),
    .o_ready(o_ready), .o_diff(o_diff), .o_borrow(o_borrow),
    .o_ovf(o_ovf), .o_valid(o_valid), .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic ov);
`ifdef CSA_SUB_OVF_EN
    return ov;
`else
    return 1'b0 & ov;
`endif
  endfunction

  task automatic run_vec(input vec_t v);
    i_sub_min = v.a;
    i_sub_sub = v.b;
    i_valid   = 1'b1;
    check("ready_before_accept", o_ready, 1);
    tick();
    i_valid = 1'b0;
    check("valid_latency1", o_valid, 0);
    tick();
    check("valid_latency2", o_valid, 1);
    check("diff", o_diff, v.d);
    check("borrow", o_borrow, v.bo);
    check("ovf", o_ovf, exp_ovf(v.ov));
    $display("vec %0d - %0d -> diff=%0d borrow=%0d ovf=%0d", v.a, v.b, o_diff, o_borrow, o_ovf);
    tick();
    check("drain", o_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{9'd300, 9'd45,  9'd255, 1'b0, 1'b1};
    vecs[1]  = '{9'd5,   9'd10,  9'd507, 1'b1, 1'b0};
    vecs[2]  = '{9'd0,   9'd1,   9'd511, 1'b1, 1'b0};
    vecs[3]  = '{9'd16,  9'd1,   9'd15,  1'b0, 1'b0};
    vecs[4]  = '{9'h0FF, 9'h100, 9'h1FF, 1'b1, 1'b1};
    vecs[5]  = '{9'h005, 9'h003, 9'd2,   1'b0, 1'b0};
    vecs[6]  = '{9'd200, 9'd200, 9'd0,   1'b0, 1'b0};
    vecs[7]  = '{9'd511, 9'd511, 9'd0,   1'b0, 1'b0};
    vecs[8]  = '{9'd256, 9'd1,   9'd255, 1'b0, 1'b1};
    vecs[9]  = '{9'd511, 9'd0,   9'd511, 1'b0, 1'b0};
    vecs[10] = '{9'd0,   9'd256, 9'd256, 1'b1, 1'b1};
    vecs[11] = '{9'd17,  9'd2,   9'd15,  1'b0, 1'b0};
    vecs[12] = '{9'd10,  9'd3,   9'd7,   1'b0, 1'b0};

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_sub_min = '0; i_sub_sub = '0;
    #12;
    check("reset_valid", o_valid, 0);
    check("reset_diff", o_diff, 0);
    check("reset_borrow", o_borrow, 0);
    check("reset_ovf", o_ovf, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", o_ready, 1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Back-to-back stream with no backpressure: one result per clock, no gaps.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        i_sub_min = vecs[k].a; i_sub_sub = vecs[k].b; i_valid = 1'b1;
        check("stream_ready", o_ready, 1);
      end else begin
        i_valid = 1'b0;
      end
      tick();
      if (k >= 1 && k <= 4) begin
        check("stream_valid", o_valid, 1);
        check("stream_diff", o_diff, vecs[k-1].d);
        $display("stream out %0d diff=%0d", k - 1, o_diff);
      end else if (k == 5) begin
        check("stream_drain", o_valid, 0);
      end
    end

    // Backpressure: two accepts fill the pipe, third pair waits, then all drain in order.
    i_ready = 1'b0;
    i_sub_min = 9'd30; i_sub_sub = 9'd10; i_valid = 1'b1;
    tick();
    check("bp_ready_second", o_ready, 1);
    i_sub_min = 9'd100; i_sub_sub = 9'd1;
    tick();
    check("bp_ready_low", o_ready, 0);
    for (int k = 0; k < 3; k++) begin
      i_sub_min = 9'(k * 37); i_sub_sub = 9'(k * 11);
      #1;
      check("bp_ready_held", o_ready, 0);
      tick();
      check("bp_valid_hold", o_valid, 1);
      check("bp_diff_hold", o_diff, 20);
      $display("stall cycle %0d diff=%0d", k, o_diff);
    end
    i_sub_min = 9'd7; i_sub_sub = 9'd8;
    i_ready = 1'b1;
    #1;
    check("bp_ready_release", o_ready, 1);
    tick();
    i_valid = 1'b0;
    check("bp_out2_valid", o_valid, 1);
    check("bp_out2_diff", o_diff, 99);
    tick();
    check("bp_out3_valid", o_valid, 1);
    check("bp_out3_diff", o_diff, 511);
    check("bp_out3_borrow", o_borrow, 1);
    tick();
    check("bp_drain", o_valid, 0);

    // Reset with both stages full discards everything immediately.
    i_ready = 1'b0;
    i_sub_min = 9'd50; i_sub_sub = 9'd5; i_valid = 1'b1;
    tick();
    i_sub_min = 9'd60; i_sub_sub = 9'd6;
    tick();
    i_valid = 1'b0;
    check("pre_reset_valid", o_valid, 1);
    check("pre_reset_diff", o_diff, 45);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", o_valid, 0);
    check("async_reset_diff", o_diff, 0);
    check("async_reset_ready", o_ready, 1);
    #3;
    rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    check("post_reset_empty", o_valid, 0);
    check("post_reset_ready", o_ready, 1);
    run_vec(vecs[12]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
